// File: rtl/if_stage.sv
// if_stage: instruction fetch with single-outstanding ROM handshake, skid buffer, delay-slot branches and flush
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        rom_req_o,
    output logic [31:0] rom_addr_o,
    input  logic        rom_ack_i,
    input  logic [31:0] rom_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {IDLE, REQ, FULL, DROP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_valid;

    logic w_fetch;
    logic w_take_br;
    logic w_release;

    assign w_fetch   = (r_state == REQ) && rom_ack_i;
    assign w_take_br = branch_flag_i && !stall_i && !flush_i;
    assign w_release = (r_state == FULL) && !stall_i;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state: flush wins over stall; a request without ack under flush must drain as DROP
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = REQ;
            REQ:     w_next = flush_i ? (rom_ack_i ? REQ : DROP) : (rom_ack_i && stall_i) ? FULL : REQ;
            FULL:    w_next = (flush_i || !stall_i) ? REQ : FULL;
            DROP:    w_next = rom_ack_i ? REQ : DROP;
            default: w_next = IDLE;
        endcase
    end

    // outputs: address comes only from registered state so it never moves during a request
    always_comb begin
        rom_req_o  = (r_state == REQ) || (r_state == DROP);
        rom_addr_o = (r_state == REQ) ? r_pc : (r_state == DROP) ? r_drop_addr : 32'h0;
    end

    // fetch pointer and pending branch; a branch seen while the delay slot is already held redirects at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_br_pend <= 1'b0;
            r_br_tgt  <= 32'h0;
        end else if (flush_i) begin
            r_pc      <= flush_pc_i;
            r_br_pend <= 1'b0;
        end else if (w_fetch) begin
            r_pc      <= w_take_br ? branch_target_i : r_br_pend ? r_br_tgt : r_pc + 32'd4;
            r_br_pend <= 1'b0;
        end else if (w_take_br && r_state == FULL) begin
            r_pc <= branch_target_i;
        end else if (w_take_br) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= branch_target_i;
        end
    end

    // remember the abandoned address so the stale request stays on the bus until acked
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                           r_drop_addr <= 32'h0;
        else if (flush_i && r_state == REQ && !rom_ack_i)  r_drop_addr <= r_pc;
    end

    // skid buffer catches an instruction that arrives while the decoder is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_i) begin
            r_skid_pc   <= 32'h0;
            r_skid_inst <= 32'h0;
        end else if (w_fetch && stall_i) begin
            r_skid_pc   <= r_pc;
            r_skid_inst <= rom_data_i;
        end
    end

    // IF/ID register: new fetch, skid drain, or bubble when nothing arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_i) begin
            r_if_pc    <= 32'h0;
            r_if_inst  <= 32'h0;
            r_if_valid <= 1'b0;
        end else if (!stall_i) begin
            r_if_pc    <= w_fetch ? r_pc : w_release ? r_skid_pc : 32'h0;
            r_if_inst  <= w_fetch ? rom_data_i : w_release ? r_skid_inst : 32'h0;
            r_if_valid <= w_fetch || w_release;
        end
    end

    assign pc_o         = r_if_pc;
    assign inst_o       = r_if_inst;
    assign inst_valid_o = r_if_valid;

endmodule
